// File: rtl/fir_decimator.sv
// FIR output decimator: warm-up discard, 1-in-DECIM keep, FWFT output FIFO.
// Define DECIM_AVG_EN to push the boxcar average of each group instead of its first sample.
module fir_decimator #(
  parameter int DATA_W     = 12,
  parameter int DECIM      = 4,
  parameter int WARMUP     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          Clk,
  input  logic                          Hlt,
  input  logic [DATA_W-1:0]             Din,
  input  logic                          Din_valid,
  output logic [DATA_W-1:0]             Dout,
  output logic                          Dout_valid,
  input  logic                          Dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
  output logic                          Overflow
);

  localparam int PW = $clog2(DECIM);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = $clog2(WARMUP + 1);

  typedef enum logic {
    WARM = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [WW-1:0] warm_q;
  logic [PW-1:0] phase_q;
  logic          warm_adv;
  logic          take;

  logic              push_req;
  logic [DATA_W-1:0] push_data;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [AW-1:0]     rd_nx;
  logic [CW-1:0]     cnt_q;
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic              ovf_q;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push_ok;

  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) state_q <= WARM;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WARM: if (Din_valid && warm_q == WW'(WARMUP - 1))
              state_d = RUN;
      RUN:  state_d = RUN;
      default: state_d = WARM;
    endcase
  end

  always_comb begin
    warm_adv = 1'b0;
    take     = 1'b0;
    unique case (state_q)
      WARM:    warm_adv = Din_valid;
      RUN:     take     = Din_valid;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      warm_q  <= '0;
      phase_q <= '0;
    end else begin
      if (warm_adv) warm_q  <= warm_q + 1'b1;
      if (take)     phase_q <= phase_q + 1'b1;
    end
  end

`ifdef DECIM_AVG_EN
  // Phase 0 restarts the sum, so no explicit clear is needed between groups.
  logic [DATA_W+PW-1:0] acc_q;
  logic [DATA_W+PW-1:0] acc_sum;

  always_comb begin
    acc_sum   = (phase_q == '0 ? '0 : acc_q) + {{PW{1'b0}}, Din};
    push_req  = take && phase_q == PW'(DECIM - 1);
    push_data = DATA_W'(acc_sum >> PW);
  end

  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt)       acc_q <= '0;
    else if (take) acc_q <= acc_sum;
  end
`else
  always_comb begin
    push_req  = take && phase_q == '0;
    push_data = Din;
  end
`endif

  assign full    = cnt_q == CW'(FIFO_DEPTH);
  assign empty   = cnt_q == '0;
  assign pop     = !empty && Dout_ready;
  assign push_ok = push_req && (!full || pop);
  assign rd_nx   = rd_q + 1'b1;

  // Registered head keeps Dout stable across an empty FIFO.
  always_comb begin
    dout_d = dout_q;
    if (pop) begin
      if (cnt_q > CW'(1)) dout_d = mem[rd_nx];
      else if (push_ok)   dout_d = push_data;
    end else if (empty && push_ok) begin
      dout_d = push_data;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem[wr_q] <= push_data;
  end

  always_ff @(posedge Clk or posedge Hlt) begin
    if (Hlt) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_nx;
      unique case ({push_ok, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      if (push_req && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign Dout       = dout_q;
  assign Dout_valid = !empty;
  assign Fifo_count = cnt_q;
  assign Overflow   = ovf_q;

endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator (DECIM=4, WARMUP=32, FIFO_DEPTH=8).
// Expected values are hand-derived from ramp and fixed-vector inputs.
module tb_fir_decimator;

`ifdef DECIM_AVG_EN
  localparam int POFF = 3;
  localparam int AOFF = 1;
`else
  localparam int POFF = 0;
  localparam int AOFF = 0;
`endif

  logic        Clk = 1'b0;
  logic        Hlt;
  logic [11:0] Din;
  logic        Din_valid;
  logic [11:0] Dout;
  logic        Dout_valid;
  logic        Dout_ready;
  logic [3:0]  Fifo_count;
  logic        Overflow;

  int errs   = 0;
  int checks = 0;
  int got[$];
  int vis;

  fir_decimator dut (
    .Clk        (Clk),
    .Hlt        (Hlt),
    .Din        (Din),
    .Din_valid  (Din_valid),
    .Dout       (Dout),
    .Dout_valid (Dout_valid),
    .Dout_ready (Dout_ready),
    .Fifo_count (Fifo_count),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int d, input bit dv, input bit rdy);
    Din        = d[11:0];
    Din_valid  = dv;
    Dout_ready = rdy;
    if (Dout_valid && rdy) got.push_back(int'(Dout));
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Hlt        = 1'b1;
    Din        = '0;
    Din_valid  = 1'b0;
    Dout_ready = 1'b0;
    @(posedge Clk);
    #1;
    Hlt = 1'b0;
    got.delete();
  endtask

  task automatic warm(input bit gaps, input bit rdy, output int v);
    v = 0;
    for (int n = 0; n < 32; n++) begin
      if (gaps) cyc(12'hABC, 1'b0, rdy);
      cyc(n, 1'b1, rdy);
      if (Dout_valid) v++;
    end
  endtask

  task automatic stream(input bit gaps, input string tag);
    warm(gaps, 1'b1, vis);
    chk({tag, "_warm_quiet"}, vis, 0);
    for (int n = 32; n < 64; n++) begin
      if (gaps) cyc(7, 1'b0, 1'b1);
      cyc(n, 1'b1, 1'b1);
      if (n == 32 + POFF) begin
        chk({tag, "_first_valid"}, Dout_valid, 1);
        chk({tag, "_first_dout"}, Dout, 32 + AOFF);
      end
    end
    for (int i = 0; i < 4; i++) cyc(0, 1'b0, 1'b1);
    chk({tag, "_nout"}, got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk({tag, "_out"}, got[i], 32 + 4 * i + AOFF);
  endtask

  initial begin
    Hlt = 1'b1;
    Din = '0;
    Din_valid = 1'b0;
    Dout_ready = 1'b0;
    #3;
    chk("rst_dout", Dout, 0);
    chk("rst_valid", Dout_valid, 0);
    chk("rst_count", Fifo_count, 0);
    chk("rst_ovf", Overflow, 0);

    // Warm-up and ramp decimation, then the same ramp with gaps.
    do_reset();
    stream(1'b0, "ramp");
    do_reset();
    stream(1'b1, "gaps");

    // Fixed vector group.
    do_reset();
    warm(1'b0, 1'b0, vis);
    cyc(100, 1'b1, 1'b0);
`ifdef DECIM_AVG_EN
    chk("vec_pre_valid", Dout_valid, 0);
    cyc(101, 1'b1, 1'b0);
    cyc(102, 1'b1, 1'b0);
    chk("vec_pre_valid2", Dout_valid, 0);
    cyc(105, 1'b1, 1'b0);
    chk("vec_valid", Dout_valid, 1);
    chk("vec_dout", Dout, 102);
`else
    chk("vec_valid", Dout_valid, 1);
    chk("vec_dout", Dout, 100);
    cyc(101, 1'b1, 1'b0);
    cyc(102, 1'b1, 1'b0);
    cyc(105, 1'b1, 1'b0);
    chk("vec_hold", Dout, 100);
    chk("vec_count", Fifo_count, 1);
`endif

    // Backpressure to full, then overflow, then drain.
    do_reset();
    warm(1'b0, 1'b0, vis);
    for (int n = 32; n < 64; n++) cyc(n, 1'b1, 1'b0);
    chk("bp_count", Fifo_count, 8);
    chk("bp_dout", Dout, 32 + AOFF);
    chk("bp_ovf0", Overflow, 0);
    for (int n = 64; n < 68; n++) cyc(n, 1'b1, 1'b0);
    chk("bp_ovf1", Overflow, 1);
    chk("bp_count_full", Fifo_count, 8);
    chk("bp_dout_hold", Dout, 32 + AOFF);
    for (int i = 0; i < 10; i++) cyc(0, 1'b0, 1'b1);
    chk("bp_ndrain", got.size(), 8);
    for (int i = 0; i < got.size() && i < 8; i++)
      chk("bp_drain", got[i], 32 + 4 * i + AOFF);
    chk("bp_empty", Fifo_count, 0);
    chk("bp_ovf_sticky", Overflow, 1);

    // Push and pop together while full.
    do_reset();
    warm(1'b0, 1'b0, vis);
    for (int n = 32; n < 64; n++) cyc(n, 1'b1, 1'b0);
    for (int n = 64; n < 64 + POFF; n++) cyc(n, 1'b1, 1'b0);
    cyc(64 + POFF, 1'b1, 1'b1);
    chk("pp_ovf", Overflow, 0);
    chk("pp_count", Fifo_count, 8);
    chk("pp_head", Dout, 36 + AOFF);
    for (int i = 0; i < 10; i++) cyc(0, 1'b0, 1'b1);
    chk("pp_nout", got.size(), 9);
    for (int i = 0; i < got.size() && i < 9; i++)
      chk("pp_out", got[i], 32 + 4 * i + AOFF);

    // Reset mid-group with five entries queued.
    do_reset();
    warm(1'b0, 1'b0, vis);
    for (int n = 32; n <= 49 + POFF; n++) cyc(n, 1'b1, 1'b0);
    chk("mid_count", Fifo_count, 5);
    Hlt = 1'b1;
    #2;
    chk("mid_valid", Dout_valid, 0);
    chk("mid_count0", Fifo_count, 0);
    chk("mid_ovf", Overflow, 0);
    chk("mid_dout", Dout, 0);
    @(posedge Clk);
    #1;
    Hlt = 1'b0;
    got.delete();
    stream(1'b0, "after");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/fir_decimator.md
Name: fir_decimator

Overview:
- Downstream stage of the 32-tap transposed FIR low-pass filter.
- Consumes the filter's 12-bit output stream and discards the pipeline warm-up samples after Hlt.
- Decimates by DECIM and buffers results in a small first-word-fall-through FIFO.
- Presents the results on a valid/ready interface to the sample consumer (DSP or UART packer).

Parameters:
- DATA_W, 12: sample width; matches FIR Dout.
- DECIM, 4: decimation ratio; power of two, 2..64.
- WARMUP, 32: input samples discarded after reset; equals the FIR tap count.
- FIFO_DEPTH, 8: output FIFO entries; power of two, 2..64.

Ports:
- Clk  in  1  system clock; all state on posedge.
- Hlt  in  1  asynchronous active-high reset, same net as the FIR's Hlt.
- Din  in  DATA_W  FIR output sample, unsigned.
- Din_valid  in  1  Din is a new sample this cycle; tied high when the FIR runs every clock.
- Dout  out  DATA_W  FIFO head sample.
- Dout_valid  out  1  FIFO not empty.
- Dout_ready  in  1  consumer accepts Dout this cycle.
- Fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
- Overflow  out  1  sticky flag: a decimated sample was dropped.

Behaviour:
- Reset values (asserting Hlt clears everything asynchronously, including mid-operation and mid-group):
  - Dout=0, Dout_valid=0, Fifo_count=0, Overflow=0.
  - Warm-up counter=0, phase counter=0, accumulator=0.
  - FIFO pointers=0; FIFO contents become unobservable.
- Only cycles with Din_valid=1 advance any counter. Din_valid=0 cycles hold all state.
- State machine, two states:
  - WARM (reset state): count valid samples and discard them. On the WARMUP-th valid sample (counter==WARMUP-1), go to RUN. That sample is also discarded.
  - RUN: stays in RUN until Hlt.
- Decimation in RUN, without DECIM_AVG_EN:
  - Phase counter runs 0..DECIM-1 and wraps to 0.
  - The sample taken at phase 0 is pushed; the other DECIM-1 samples are dropped.
  - The first RUN sample is at phase 0.
- Push timing: the push happens in the same clock edge that the sample is taken. Dout/Dout_valid therefore reflect it one cycle after Din is presented, if the FIFO was empty.
- FIFO behaviour:
  - First-word fall-through: Dout always shows the head entry. Pop occurs when Dout_valid && Dout_ready.
  - Dout_ready while empty has no effect.
  - Dout holds its last value when the FIFO is empty; it is not required to be 0 after the first pop.
- Push while full with no pop in the same cycle: the new sample is dropped, Overflow is set, and FIFO contents are unchanged.
- Push while full with a pop in the same cycle: the push is accepted and Overflow is not set. Count stays at FIFO_DEPTH.
- Push and pop in the same cycle when not full: count is unchanged and ordering is preserved.
- Overflow is cleared only by Hlt.
- Pointers wrap modulo FIFO_DEPTH. Fifo_count is 0..FIFO_DEPTH.

Optional Feature:
- Macro: DECIM_AVG_EN.
- Defined (boxcar average):
  - Accumulator is DATA_W+log2(DECIM) bits, unsigned.
  - Phase 0 loads Din; phases 1..DECIM-1 add Din.
  - At phase DECIM-1 the block pushes (acc+Din)>>log2(DECIM), truncating toward zero, and the accumulator is reloaded on the next phase 0.
  - The first push occurs on RUN sample DECIM-1.
- Undefined: pure sample drop as above, with no accumulator logic synthesized.

Test Plan:
- Warm-up: Hlt pulse, then Din=n for n=0,1,2,… at Din_valid=1 every cycle with Dout_ready=1. Require Dout_valid=0 for the first 32 samples; the first output is Dout=32, then 36, 40, … (no avg).
- Averaging (DECIM_AVG_EN): after warm-up, feed samples 100,101,102,105. Require Dout=102 (408>>2), with Dout_valid rising one cycle after the 105 sample.
- Backpressure/overflow: Dout_ready=0 after warm-up with DECIM=4. Require Fifo_count to reach 8 after 32 RUN samples. The 9th decimated sample sets Overflow=1 and Dout stays at the first kept value. Then Dout_ready=1 drains exactly 8 values in order.
- Full with simultaneous push and pop: at count=8, assert Dout_ready=1 on the same cycle as a push. Require Overflow to stay 0, count to stay 8, and the new sample to appear last.
- Din_valid gaps: insert Din_valid=0 cycles between samples. Require output values to be identical to the gap-free run.
- Reset mid-operation: assert Hlt with count=5 in RUN mid-group. Require immediate Dout_valid=0, count=0, Overflow=0. After release, 32 samples are again discarded before the first output.
